mask_centroid: RTL and testbench
================================

Name: mask_centroid

Overview:
- Per-camera centroid stage. Consumes one camera's pixel stream plus a 1-bit colour-threshold mask, accumulates x/y sums of masked pixels over a frame, and divides by the pixel count at frame end.
- Emits the tracked object's 12-bit x (and y) centroid, zero-extended from the 11-/10-bit divider results.
- Two instances, one per camera, feed the stereo depth stage's x_1_in/x_2_in directly.

Parameters:
- H_WIDTH, 1280, active pixels per line; x_in width = $clog2(H_WIDTH) = 11
- V_HEIGHT, 720, active lines per frame; y_in width = $clog2(V_HEIGHT) = 10
- MIN_COUNT, 64, minimum masked pixels for a valid detection
- DIV_WIDTH, 32, dividend/divisor width and divider iteration count

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- valid_in  input  1  pixel qualifier
- x_in  input  11  pixel column
- y_in  input  10  pixel row
- mask_in  input  1  pixel belongs to object
- frame_done_in  input  1  one-cycle pulse, frame complete
- x_out  output  12  centroid column
- y_out  output  10  centroid row
- found_out  output  1  last result met MIN_COUNT
- valid_out  output  1  one-cycle pulse, new result
- busy_out  output  1  divide in progress
- drop_out  output  1  one-cycle pulse, frame_done ignored

Behaviour:
- Reset: async on rst_n_in low. All outputs 0, accumulators 0, state IDLE_ACC.
- Accumulation, every cycle with valid_in && mask_in:
  - sum_x += x_in (31 bits)
  - sum_y += y_in (30 bits)
  - count += 1 (20 bits)
  - Widths are sized so no overflow is possible for a full frame.
- frame_done_in at cycle T while in IDLE_ACC:
  - Snapshot sum_x, sum_y, count (including any masked pixel qualified in cycle T).
  - Clear accumulators at T+1; pixels from T+1 onward go to the next frame.
- State machine IDLE_ACC -> DIVIDE -> REPORT -> IDLE_ACC.
  - DIVIDE: two divider instances start at T+1 with a shared divisor = count, DIV_WIDTH iterations each. done at T+33.
  - REPORT lasts one cycle (T+34):
    - valid_out = 1.
    - If count >= MIN_COUNT: found_out = 1; x_out/y_out = truncated quotients, zero-extended to 12/10 bits.
    - Else: found_out = 0; x_out/y_out hold their previous values.
  - Result latency is exactly 34 cycles after frame_done_in.
- count == 0: the divider is not started, so the divider never sees zero. Path still takes 34 cycles, reports found_out = 0, holds previous x_out/y_out.
- busy_out is high T+1 through T+34 inclusive.
- Accumulation continues during DIVIDE/REPORT.
- frame_done_in while busy_out = 1:
  - Pulse ignored; drop_out pulses the next cycle.
  - Accumulators are not cleared, so that frame merges into the next one.
- x_out, y_out, found_out are stable between valid_out pulses.
- Reset asserted mid-divide: divide is abandoned; no valid_out after release.

Decomposition:
- Shared package (centroid_pkg):
  - Widths: X_W = 11, Y_W = 10, SUMX_W = 31, SUMY_W = 30, CNT_W = 20
  - State enum: IDLE_ACC, DIVIDE, REPORT
- Sub-module seq_divider (restoring, one quotient bit per cycle):
  - Inputs: start, dividend, divisor, async active-low reset.
  - Outputs: quotient, remainder, done pulse.
  - Instantiated twice, for x and y.

Test Plan:
- Masked pixels x = 100..103 on row 10, then frame_done -> 34 cycles later: valid_out; found_out = 0 (count 4 < 64); x_out/y_out unchanged. Rerun with MIN_COUNT = 4 -> x_out = 101 (406/4 truncated), y_out = 10, found_out = 1.
- 8x8 block, x 600..607, y 300..307, all masked (count 64) -> x_out = 603, y_out = 303, found_out = 1, exact 34-cycle latency.
- Frame with no masked pixels -> valid_out at T+34, found_out = 0, x_out holds prior 603.
- Masked pixel coincident with frame_done plus block of 64 at x = 1279 -> pixel counted in the ending frame; x_out = 1279 (no overflow at max column).
- Second frame_done at T+10 -> drop_out pulse at T+11; only one valid_out; next frame's count includes the merged pixels.
- rst_n_in low at T+15 mid-divide -> outputs 0 immediately; no valid_out after release; next frame computes correctly.

Source files
------------

// File: rtl/centroid_pkg.sv
// Shared widths and state encoding for the per-camera mask centroid stage.
package centroid_pkg;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int SUMX_W = 31;
  localparam int SUMY_W = 30;
  localparam int CNT_W  = 20;

  typedef enum logic [1:0] {
    IDLE_ACC = 2'd0,
    DIVIDE   = 2'd1,
    REPORT   = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, WIDTH iterations.
// done pulses the cycle after the final iteration; a start mid-divide restarts it.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // The dividend register doubles as the quotient shift register.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo <= i_dividend;
        r_rem <= '0;
        r_div <= i_divisor;
        r_cnt <= CNT_W'(WIDTH);
      end else if (r_cnt != '0) begin
        if (!w_diff[WIDTH]) begin
          r_rem <= w_diff[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_done      = r_done;

endmodule

// File: rtl/mask_centroid.sv
// Accumulates masked pixel coordinates over a frame and reports the centroid
// exactly 34 cycles after frame_done_in; frame_done_in while busy is dropped.
module mask_centroid
  import centroid_pkg::*;
#(
  parameter int H_WIDTH   = 1280,
  parameter int V_HEIGHT  = 720,
  parameter int MIN_COUNT = 64,
  parameter int DIV_WIDTH = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        valid_in,
  input  logic [$clog2(H_WIDTH)-1:0]  x_in,
  input  logic [$clog2(V_HEIGHT)-1:0] y_in,
  input  logic                        mask_in,
  input  logic                        frame_done_in,
  output logic [X_W:0]                x_out,
  output logic [Y_W-1:0]              y_out,
  output logic                        found_out,
  output logic                        valid_out,
  output logic                        busy_out,
  output logic                        drop_out
);

  localparam int PH_W = $clog2(DIV_WIDTH + 1);

  state_t              r_state;
  state_t              w_nextState;

  logic [SUMX_W-1:0]   r_sumX;
  logic [SUMY_W-1:0]   r_sumY;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_countSnap;
  logic [PH_W-1:0]     r_phase;
  logic [X_W:0]        r_xOut;
  logic [Y_W-1:0]      r_yOut;
  logic                r_found;
  logic                r_drop;

  logic                w_pix;
  logic                w_accept;
  logic                w_divStart;
  logic                w_divEnd;
  logic                w_reportOk;
  logic                w_busy;
  logic                w_valid;
  logic [SUMX_W-1:0]   w_snapX;
  logic [SUMY_W-1:0]   w_snapY;
  logic [CNT_W-1:0]    w_snapCnt;
  logic [DIV_WIDTH-1:0] w_quoX;
  logic [DIV_WIDTH-1:0] w_quoY;
  logic [DIV_WIDTH-1:0] w_remX;
  logic [DIV_WIDTH-1:0] w_remY;
  logic                w_doneX;
  logic                w_doneY;
  logic                w_unused;

  assign w_pix    = valid_in & mask_in;
  assign w_accept = frame_done_in && (r_state == IDLE_ACC);

  // The snapshot includes a masked pixel arriving in the same cycle as frame_done.
  assign w_snapX   = r_sumX + (w_pix ? SUMX_W'(x_in) : '0);
  assign w_snapY   = r_sumY + (w_pix ? SUMY_W'(y_in) : '0);
  assign w_snapCnt = r_count + CNT_W'(w_pix);

  assign w_divStart = w_accept && (w_snapCnt != '0);
  assign w_divEnd   = (r_state == DIVIDE) && (r_phase == '0);
  assign w_reportOk = r_countSnap >= CNT_W'(MIN_COUNT);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sumX  <= '0;
      r_sumY  <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_sumX  <= '0;
      r_sumY  <= '0;
      r_count <= '0;
    end else if (w_pix) begin
      r_sumX  <= w_snapX;
      r_sumY  <= w_snapY;
      r_count <= w_snapCnt;
    end
  end

  // The phase counter times DIVIDE even when count is zero and no divide runs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_phase     <= '0;
      r_countSnap <= '0;
    end else if (w_accept) begin
      r_phase     <= PH_W'(DIV_WIDTH);
      r_countSnap <= w_snapCnt;
    end else if ((r_state == DIVIDE) && (r_phase != '0)) begin
      r_phase     <= r_phase - 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_xOut  <= '0;
      r_yOut  <= '0;
      r_found <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= frame_done_in && (r_state != IDLE_ACC);
      if (w_divEnd) begin
        r_found <= w_reportOk;
        if (w_reportOk && w_doneX && w_doneY) begin
          r_xOut <= {1'b0, w_quoX[X_W-1:0]};
          r_yOut <= w_quoY[Y_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE_ACC;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE_ACC: if (w_accept) w_nextState = DIVIDE;
      DIVIDE:   if (w_divEnd) w_nextState = REPORT;
      REPORT:   w_nextState = IDLE_ACC;
      default:  w_nextState = IDLE_ACC;
    endcase
  end

  always_comb begin
    w_busy  = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      DIVIDE:  w_busy = 1'b1;
      REPORT: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
      end
      default: ;
    endcase
  end

  seq_divider #(.WIDTH(DIV_WIDTH)) u_divX (
    .i_clk       (clk_in),
    .i_rst_n     (rst_n_in),
    .i_start     (w_divStart),
    .i_dividend  (DIV_WIDTH'(w_snapX)),
    .i_divisor   (DIV_WIDTH'(w_snapCnt)),
    .o_quotient  (w_quoX),
    .o_remainder (w_remX),
    .o_done      (w_doneX)
  );

  seq_divider #(.WIDTH(DIV_WIDTH)) u_divY (
    .i_clk       (clk_in),
    .i_rst_n     (rst_n_in),
    .i_start     (w_divStart),
    .i_dividend  (DIV_WIDTH'(w_snapY)),
    .i_divisor   (DIV_WIDTH'(w_snapCnt)),
    .o_quotient  (w_quoY),
    .o_remainder (w_remY),
    .o_done      (w_doneY)
  );

  // Quotient high bits are provably zero and remainders are not reported.
  assign w_unused = ^{w_quoX[DIV_WIDTH-1:X_W], w_quoY[DIV_WIDTH-1:Y_W], w_remX, w_remY};

  assign x_out     = r_xOut;
  assign y_out     = r_yOut;
  assign found_out = r_found;
  assign valid_out = w_valid;
  assign busy_out  = w_busy;
  assign drop_out  = r_drop;

endmodule

// File: tb/tb_mask_centroid.sv
// Drives two centroid instances (MIN_COUNT 64 and 4) with directed and random
// frames and compares every output each cycle against a frame-level model.
module tb_mask_centroid;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        validIn = 1'b0;
  logic        maskIn = 1'b0;
  logic        frameDone = 1'b0;
  logic [10:0] xIn = '0;
  logic [9:0]  yIn = '0;

  logic [11:0] xOutA, xOutB;
  logic [9:0]  yOutA, yOutB;
  logic        foundA, foundB, validA, validB, busyA, busyB, dropA, dropB;

  always #5 clk = ~clk;

  mask_centroid #(.MIN_COUNT(64)) dutA (
    .clk_in        (clk),
    .rst_n_in      (rstN),
    .valid_in      (validIn),
    .x_in          (xIn),
    .y_in          (yIn),
    .mask_in       (maskIn),
    .frame_done_in (frameDone),
    .x_out         (xOutA),
    .y_out         (yOutA),
    .found_out     (foundA),
    .valid_out     (validA),
    .busy_out      (busyA),
    .drop_out      (dropA)
  );

  mask_centroid #(.MIN_COUNT(4)) dutB (
    .clk_in        (clk),
    .rst_n_in      (rstN),
    .valid_in      (validIn),
    .x_in          (xIn),
    .y_in          (yIn),
    .mask_in       (maskIn),
    .frame_done_in (frameDone),
    .x_out         (xOutB),
    .y_out         (yOutB),
    .found_out     (foundB),
    .valid_out     (validB),
    .busy_out      (busyB),
    .drop_out      (dropB)
  );

  int     checks = 0;
  int     errors = 0;
  int     cycleNo = 0;
  bit     pending = 0;
  int     reportCycle = -100;
  int     dropCycle = -100;
  longint accSx = 0, accSy = 0, accCnt = 0;
  longint pendSx = 0, pendSy = 0, pendCnt = 0;
  int     minCount [2];
  int     expX [2];
  int     expY [2];
  bit     expFound [2];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, cycleNo, obs, exp);
    end
  endtask

  task automatic checkAll();
    bit eValid, eBusy, eDrop;
    eValid = pending && (cycleNo == reportCycle);
    eBusy  = pending && (cycleNo >= reportCycle - 33) && (cycleNo <= reportCycle);
    eDrop  = (cycleNo == dropCycle);
    checkOutput("A.x_out",     32'(xOutA),  32'(expX[0]));
    checkOutput("A.y_out",     32'(yOutA),  32'(expY[0]));
    checkOutput("A.found_out", 32'(foundA), 32'(expFound[0]));
    checkOutput("A.valid_out", 32'(validA), 32'(eValid));
    checkOutput("A.busy_out",  32'(busyA),  32'(eBusy));
    checkOutput("A.drop_out",  32'(dropA),  32'(eDrop));
    checkOutput("B.x_out",     32'(xOutB),  32'(expX[1]));
    checkOutput("B.y_out",     32'(yOutB),  32'(expY[1]));
    checkOutput("B.found_out", 32'(foundB), 32'(expFound[1]));
    checkOutput("B.valid_out", 32'(validB), 32'(eValid));
    checkOutput("B.busy_out",  32'(busyB),  32'(eBusy));
    checkOutput("B.drop_out",  32'(dropB),  32'(eDrop));
  endtask

  // One clock cycle of stimulus; the model decides what this cycle means for the frame.
  task automatic applyStimulus(input bit v, input int x, input int y, input bit m, input bit fd);
    validIn   = v;
    xIn       = 11'(x);
    yIn       = 10'(y);
    maskIn    = m;
    frameDone = fd;
    if (v && m) begin
      accSx += x;
      accSy += y;
      accCnt++;
    end
    if (fd) begin
      if (pending && cycleNo <= reportCycle) begin
        dropCycle = cycleNo + 1;
      end else begin
        pendSx = accSx;
        pendSy = accSy;
        pendCnt = accCnt;
        accSx = 0;
        accSy = 0;
        accCnt = 0;
        pending = 1;
        reportCycle = cycleNo + 34;
      end
    end
    @(posedge clk);
    #1;
    cycleNo++;
    if (pending && cycleNo == reportCycle) begin
      for (int i = 0; i < 2; i++) begin
        if (pendCnt >= minCount[i]) begin
          expFound[i] = 1;
          expX[i] = int'(pendSx / pendCnt);
          expY[i] = int'(pendSy / pendCnt);
        end else begin
          expFound[i] = 0;
        end
      end
    end
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic doReset(input int n);
    rstN = 1'b0;
    validIn = 1'b0;
    maskIn = 1'b0;
    frameDone = 1'b0;
    #1;
    accSx = 0;
    accSy = 0;
    accCnt = 0;
    pending = 0;
    dropCycle = -100;
    for (int i = 0; i < 2; i++) begin
      expX[i] = 0;
      expY[i] = 0;
      expFound[i] = 0;
    end
    checkAll();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cycleNo++;
    end
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    minCount[0] = 64;
    minCount[1] = 4;
    #2;
    doReset(3);
    idle(2);

    // Four pixels on row 10: below 64 for A, above 4 for B.
    for (int i = 0; i < 4; i++) applyStimulus(1, 100 + i, 10, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    idle(33);
    checkOutput("plan.B.x101", 32'(xOutB), 32'd101);
    checkOutput("plan.B.y10", 32'(yOutB), 32'd10);
    checkOutput("plan.B.found", 32'(foundB), 32'd1);
    checkOutput("plan.A.notfound", 32'(foundA), 32'd0);
    checkOutput("plan.A.xhold", 32'(xOutA), 32'd0);
    idle(4);

    // 8x8 block with interleaved unmasked pixels.
    for (int y = 300; y < 308; y++) begin
      for (int x = 600; x < 608; x++) begin
        applyStimulus(1, x, y, 1, 0);
        applyStimulus(1, 5, 5, 0, 0);
      end
    end
    applyStimulus(0, 0, 0, 0, 1);
    idle(33);
    checkOutput("plan.A.x603", 32'(xOutA), 32'd603);
    checkOutput("plan.A.y303", 32'(yOutA), 32'd303);
    checkOutput("plan.A.valid", 32'(validA), 32'd1);
    idle(4);

    // Empty frame: zero count, previous result held.
    applyStimulus(0, 0, 0, 0, 1);
    idle(33);
    checkOutput("plan.empty.found", 32'(foundA), 32'd0);
    checkOutput("plan.empty.xhold", 32'(xOutA), 32'd603);
    idle(4);

    // 64 pixels at the last column plus one coincident with frame_done.
    for (int y = 0; y < 64; y++) applyStimulus(1, 1279, y, 1, 0);
    applyStimulus(1, 1279, 100, 1, 1);
    idle(33);
    checkOutput("plan.maxcol.x1279", 32'(xOutA), 32'd1279);
    idle(4);

    // Second frame_done at T+10 is dropped and its pixels merge forward.
    for (int i = 0; i < 70; i++) applyStimulus(1, $urandom_range(0, 1279), $urandom_range(0, 719), 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) applyStimulus(1, $urandom_range(0, 1279), $urandom_range(0, 719), 1, 0);
    applyStimulus(1, 640, 360, 1, 1);
    checkOutput("plan.drop", 32'(dropA), 32'd1);
    for (int i = 0; i < 60; i++) applyStimulus(1, $urandom_range(0, 1279), $urandom_range(0, 719), 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    idle(36);

    // Reset in the middle of a divide.
    for (int i = 0; i < 80; i++) applyStimulus(1, $urandom_range(0, 1279), $urandom_range(0, 719), 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    idle(14);
    doReset(2);
    idle(40);
    for (int i = 0; i < 64; i++) applyStimulus(1, 200 + (i % 8), 50 + (i / 8), 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    idle(36);

    // Random frames; next frame's pixels start during the divide.
    for (int f = 0; f < 8; f++) begin
      int npix;
      npix = $urandom_range(20, 200);
      for (int i = 0; i < npix; i++) begin
        applyStimulus($urandom_range(0, 1), $urandom_range(0, 1279), $urandom_range(0, 719),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
      end
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1279), $urandom_range(0, 719), 1, 1);
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
